// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM state encoding
// and CRC-16/CCITT constants plus a single-bit CRC step helper.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ccff_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One serial CRC-16 step, MSB-first (feedback = crc[15] ^ incoming bit).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Byte-stream valid/ready channel feeding the configuration-chain loader.
// The host side uses the master modport, the loader the slave modport.
interface ccff_bitstream_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_bitstream_loader_crc16.sv
// Serial CRC-16/CCITT accumulator: one bit per enabled cycle, synchronous
// clear to the CRC seed; clear has priority over enable.
module ccff_crc16
  import ccff_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  // Next CRC value: seed on clear, advance one bit on enable.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = crc16_step(crc_q, din);
    end
  end

  // CRC register; reads as zero out of reset until the first clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 16'h0000;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain (ccff) loader: takes bytes over a valid/ready channel and
// serialises exactly CHAIN_LEN bits MSB-first onto ccff_head, with ccff_shift_en
// qualifying each chain advance. A 1-byte holding register backs an 8-bit shift
// register so a continuous stream shifts one bit per cycle without bubbles.
// Optional feature macro: CCFF_LOADER_CRC_EN (CRC-16 of the ccff_tail stream).
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter  int CHAIN_LEN = 11,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  ccff_bitstream_loader_if.slave s_if,
  output logic                  ccff_head,
  output logic                  ccff_shift_en,
  input  logic                  ccff_tail,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [CNT_W-1:0]      bit_count,
  output logic [15:0]           tail_crc
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN);

  ccff_state_e      state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       shift_cnt_q, shift_cnt_d;   // bits still held in shift_q
  logic             head_q, head_d;
  logic             shift_en_q, shift_en_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             crc_clr;
  logic             accept;
  logic             emit;

  assign cfg_busy     = (state_q == LOAD);
  assign s_if.s_ready = cfg_busy & ~hold_full_q;
  assign accept       = s_if.s_valid & s_if.s_ready;

  // Next-state, datapath and status computation; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    shift_cnt_d = shift_cnt_q;
    head_d      = head_q;
    shift_en_d  = 1'b0;
    bit_count_d = bit_count_q;
    done_d      = done_q;
    err_d       = err_q;
    crc_clr     = 1'b0;
    emit        = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (cfg_start) begin
          state_d     = LOAD;
          done_d      = 1'b0;
          err_d       = 1'b0;
          bit_count_d = '0;
          crc_clr     = 1'b1;
          hold_full_d = 1'b0;
          shift_cnt_d = 4'd0;
        end
      end
      LOAD: begin
        if (bit_count_q == LAST_BIT) begin
          // Chain is full: discard pad bits and any byte still buffered.
          state_d     = DONE;
          done_d      = 1'b1;
          hold_full_d = 1'b0;
          shift_cnt_d = 4'd0;
        end else begin
          if (shift_cnt_q != 4'd0) begin
            emit        = 1'b1;
            head_d      = shift_q[7];
            shift_d     = {shift_q[6:0], 1'b0};
            shift_cnt_d = shift_cnt_q - 4'd1;
          end else if (hold_full_q) begin
            // Shift reg empty: take the MSB straight from the holding reg and
            // refill the shift reg in the same cycle to avoid a bubble.
            emit        = 1'b1;
            head_d      = hold_q[7];
            shift_d     = {hold_q[6:0], 1'b0};
            shift_cnt_d = 4'd7;
            hold_full_d = 1'b0;
          end
          if (emit) begin
            shift_en_d  = 1'b1;
            bit_count_d = bit_count_q + CNT_W'(1);
          end
          // s_ready implies the holding reg was empty at the start of the cycle.
          if (accept) begin
            hold_d      = s_if.s_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (cfg_abort) begin
      state_d     = IDLE;
      err_d       = 1'b1;
      done_d      = done_q;
      shift_en_d  = 1'b0;
      head_d      = head_q;
      bit_count_d = bit_count_q;
      hold_full_d = 1'b0;
      shift_cnt_d = 4'd0;
      crc_clr     = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      shift_cnt_q <= 4'd0;
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      bit_count_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      shift_cnt_q <= shift_cnt_d;
      head_q      <= head_d;
      shift_en_q  <= shift_en_d;
      bit_count_q <= bit_count_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
  assign bit_count     = bit_count_q;

`ifdef CCFF_LOADER_CRC_EN
  // Signs the bits leaving the chain tail, i.e. the previous configuration.
  ccff_crc16 u_crc (
    .clk   (prog_clk),
    .rst_n (prog_reset_n),
    .clr   (crc_clr),
    .en    (shift_en_q),
    .din   (ccff_tail),
    .crc   (tail_crc)
  );
`else
  logic unused_crc_inputs;
  assign unused_crc_inputs = ccff_tail ^ crc_clr;
  assign tail_crc          = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Self-checking bench for ccff_bitstream_loader (CHAIN_LEN = 11).
// Expected chain bits are queued when bytes are accepted and popped by a
// monitor on every ccff_shift_en cycle.
module tb_ccff_bitstream_loader;

  localparam int CHAIN_LEN = 11;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

  logic             prog_clk = 1'b0;
  logic             prog_reset_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic             cfg_abort = 1'b0;
  logic             ccff_head;
  logic             ccff_shift_en;
  logic             ccff_tail = 1'b1;
  logic             cfg_busy;
  logic             cfg_done;
  logic             cfg_err;
  logic [CNT_W-1:0] bit_count;
  logic [15:0]      tail_crc;

  ccff_bitstream_loader_if sif ();

  ccff_bitstream_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .s_if          (sif),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .bit_count     (bit_count),
    .tail_crc      (tail_crc)
  );

  always #5 prog_clk = ~prog_clk;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_q[$];
  int   pushed = 0;
  int   cyc = 0;
  int   shifts = 0;
  int   first_cyc = -1;
  int   last_cyc = -1;
  int   max_gap = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_ref_ones(input int nbits);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < nbits; i++) begin
      if (c[15] ^ 1'b1) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Monitor: sample 2 ns after each rising edge, compare every shifted bit.
  always @(posedge prog_clk) begin
    #2;
    cyc++;
    if (ccff_shift_en) begin
      if (first_cyc < 0) first_cyc = cyc;
      if (last_cyc >= 0 && (cyc - last_cyc - 1) > max_gap) max_gap = cyc - last_cyc - 1;
      last_cyc = cyc;
      shifts++;
      if (exp_q.size() == 0) check_val("spurious_shift", 32'(ccff_shift_en), 32'd0);
      else                   check_val("head", 32'(ccff_head), 32'(exp_q.pop_front()));
    end
  end

  // Pulse cfg_start (called and returns on a falling edge).
  task automatic begin_load();
    shifts = 0; first_cyc = -1; last_cyc = -1; max_gap = 0; pushed = 0;
    exp_q.delete();
    cfg_start = 1'b1;
    @(negedge prog_clk);
    cfg_start = 1'b0;
  endtask

  // Offer one byte; returns the cycle in which it was accepted.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    sif.s_data  = b;
    sif.s_valid = 1'b1;
    while (!sif.s_ready && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    if (sif.s_ready) begin
      acc_cyc = cyc;
      for (int i = 7; i >= 0; i--) begin
        if (pushed < CHAIN_LEN) begin
          exp_q.push_back(b[i]);
          pushed++;
        end
      end
      $display("byte 0x%02h accepted in cycle %0d", b, cyc);
    end else begin
      check_val("accept_timeout", 32'(sif.s_ready), 32'd1);
    end
    @(negedge prog_clk);
    sif.s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!cfg_done && n < 200) begin
      @(negedge prog_clk);
      n++;
    end
    check_val("done_timeout", 32'(cfg_done), 32'd1);
  endtask

  task automatic wait_shifts(input int target);
    int n;
    n = 0;
    while (shifts < target && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    check_val("shift_wait", 32'(shifts), 32'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_head"},   32'(ccff_head),     32'd0);
    check_val({tag, "_sen"},    32'(ccff_shift_en), 32'd0);
    check_val({tag, "_busy"},   32'(cfg_busy),      32'd0);
    check_val({tag, "_done"},   32'(cfg_done),      32'd0);
    check_val({tag, "_err"},    32'(cfg_err),       32'd0);
    check_val({tag, "_cnt"},    32'(bit_count),     32'd0);
    check_val({tag, "_sready"}, 32'(sif.s_ready),   32'd0);
    check_val({tag, "_crc"},    32'(tail_crc),      32'd0);
  endtask

  initial begin
    int acc1, acc2, sh0, exp_gap;
    logic [15:0] exp_crc;
    sif.s_data  = 8'h00;
    sif.s_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge prog_clk);
    check_all_zero("reset");
    prog_reset_n = 1'b1;
    @(negedge prog_clk);

    // Test 1: back-to-back bytes, latency, no bubbles
    begin_load();
    check_val("t1_busy", 32'(cfg_busy), 32'd1);
    send_byte(8'hA5, acc1);
    send_byte(8'hC0, acc2);
    wait_done();
    check_val("t1_latency", 32'(first_cyc - acc1), 32'd2);
    check_val("t1_shifts",  32'(shifts),    32'(CHAIN_LEN));
    check_val("t1_gap",     32'(max_gap),   32'd0);
    check_val("t1_cnt",     32'(bit_count), 32'(CHAIN_LEN));
    check_val("t1_busy_end", 32'(cfg_busy), 32'd0);
    check_val("t1_err",     32'(cfg_err),   32'd0);
`ifdef CCFF_LOADER_CRC_EN
    exp_crc = crc_ref_ones(CHAIN_LEN);
`else
    exp_crc = 16'h0000;
`endif
    check_val("t6_crc", 32'(tail_crc), 32'(exp_crc));

    // Test 2: underrun gap between bytes
    begin_load();
    send_byte(8'hA5, acc1);
    repeat (9) @(negedge prog_clk);
    repeat (5) @(negedge prog_clk);
    send_byte(8'hC0, acc2);
    wait_done();
    // Byte 1 bits occupy acc1+2..acc1+9; byte 2 starts at acc2+2.
    exp_gap = (acc2 + 2) - (acc1 + 9) - 1;
    check_val("t2_gap",    32'(max_gap),   32'(exp_gap));
    check_val("t2_shifts", 32'(shifts),    32'(CHAIN_LEN));
    check_val("t2_err",    32'(cfg_err),   32'd0);
    check_val("t2_cnt",    32'(bit_count), 32'(CHAIN_LEN));

    // Test 3: abort after 4 bits, then restart clears status
    begin_load();
    send_byte(8'hA5, acc1);
    wait_shifts(4);
    cfg_abort = 1'b1;
    @(negedge prog_clk);
    cfg_abort = 1'b0;
    exp_q.delete();
    check_val("t3_sen",    32'(ccff_shift_en), 32'd0);
    check_val("t3_err",    32'(cfg_err),       32'd1);
    check_val("t3_busy",   32'(cfg_busy),      32'd0);
    check_val("t3_cnt",    32'(bit_count),     32'd4);
    check_val("t3_sready", 32'(sif.s_ready),   32'd0);
    repeat (2) @(negedge prog_clk);
    check_val("t3_cnt_frozen", 32'(bit_count), 32'd4);
    begin_load();
    check_val("t3_err_clr", 32'(cfg_err),   32'd0);
    check_val("t3_cnt_clr", 32'(bit_count), 32'd0);
    send_byte(8'h3C, acc1);
    send_byte(8'h96, acc2);
    wait_done();
    check_val("t3_reload_cnt", 32'(bit_count), 32'(CHAIN_LEN));

    // Test 4: asynchronous reset mid-byte, then full reload
    begin_load();
    send_byte(8'hA5, acc1);
    wait_shifts(3);
    #2;
    prog_reset_n = 1'b0;
    #1;
    check_all_zero("t4_async");
    exp_q.delete();
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    @(negedge prog_clk);
    begin_load();
    send_byte(8'hA5, acc1);
    send_byte(8'hC0, acc2);
    wait_done();
    check_val("t4_shifts", 32'(shifts),    32'(CHAIN_LEN));
    check_val("t4_cnt",    32'(bit_count), 32'(CHAIN_LEN));
    check_val("t4_busy",   32'(cfg_busy),  32'd0);

    // Test 5: s_valid held in DONE is ignored
    sh0 = shifts;
    sif.s_data  = 8'hFF;
    sif.s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_val("t5_sready", 32'(sif.s_ready), 32'd0);
      @(negedge prog_clk);
    end
    sif.s_valid = 1'b0;
    check_val("t5_shifts", 32'(shifts),   32'(sh0));
    check_val("t5_done",   32'(cfg_done), 32'd1);
    check_val("t5_err",    32'(cfg_err),  32'd0);
    check_val("t5_cnt",    32'(bit_count), 32'(CHAIN_LEN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
